// File: rtl/branch_predictor_bht_if.sv
// Fetch/EX-side bundle for the branch predictor: IF0 lookup, EX training and IF1 prediction.
interface branch_predictor_bht_if #(
  parameter int WORD = 32
);
  logic            lk_en;
  logic [WORD-1:0] lk_pc;
  logic            stall;
  logic            flush;
  logic            upd_valid;
  logic [WORD-1:0] upd_pc;
  logic            upd_taken;
  logic [WORD-1:0] upd_target;
  logic            upd_mispredict;
  logic            pred_valid;
  logic [WORD-1:0] pred_pc;
  logic            pred_taken;
  logic [WORD-1:0] pred_target;
  logic [WORD-1:0] mispred_cnt;

  modport master (
    output lk_en, lk_pc, stall, flush,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    input  pred_valid, pred_pc, pred_taken, pred_target, mispred_cnt
  );

  modport slave (
    input  lk_en, lk_pc, stall, flush,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    output pred_valid, pred_pc, pred_taken, pred_target, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor_bht.sv
// Per-PC 2-bit BHT plus direct-mapped tagged BTB; lookup in IF0, registered prediction in IF1,
// trained from EX. Lookups read the arrays as they stood before the edge (read-old).
module branch_predictor_bht #(
  parameter int         WORD     = 32,
  parameter int         BHT_LOG  = 6,
  parameter int         BTB_LOG  = 4,
  parameter int         TAG_W    = 8,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input logic                   clk,
  input logic                   rst,
  branch_predictor_bht_if.slave bp
);
  localparam int BHT_N = 1 << BHT_LOG;
  localparam int BTB_N = 1 << BTB_LOG;

  logic [1:0]       cnt     [BHT_N];
  logic [BTB_N-1:0] btb_vld;
  logic [TAG_W-1:0] btb_tag [BTB_N];
  logic [WORD-1:0]  btb_tgt [BTB_N];

  logic [BHT_LOG-1:0] lk_bidx, up_bidx;
  logic [BTB_LOG-1:0] lk_tidx, up_tidx;
  logic [TAG_W-1:0]   lk_tag, up_tag;
  logic               lk_hit;
  logic [1:0]         cnt_cur, cnt_nxt;

  assign lk_bidx = bp.lk_pc[BHT_LOG+1:2];
  assign lk_tidx = bp.lk_pc[BTB_LOG+1:2];
  assign lk_tag  = bp.lk_pc[BTB_LOG+TAG_W+1:BTB_LOG+2];
  assign up_bidx = bp.upd_pc[BHT_LOG+1:2];
  assign up_tidx = bp.upd_pc[BTB_LOG+1:2];
  assign up_tag  = bp.upd_pc[BTB_LOG+TAG_W+1:BTB_LOG+2];
  assign lk_hit  = btb_vld[lk_tidx] && (btb_tag[lk_tidx] == lk_tag);

  // Bits of upd_pc outside the index/tag fields are intentionally ignored.
  logic unused_upd_pc;
  assign unused_upd_pc = ^bp.upd_pc;

  always_comb begin
    cnt_cur = cnt[up_bidx];
    cnt_nxt = cnt_cur;
    if (bp.upd_taken) begin
      if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'd1;
    end else begin
      if (cnt_cur != 2'b00) cnt_nxt = cnt_cur - 2'd1;
    end
  end

  // One saturating counter per BHT entry; only the addressed one moves.
  for (genvar g = 0; g < BHT_N; g++) begin : g_bht
    always_ff @(posedge clk) begin
      if (rst)                                                cnt[g] <= CNT_INIT;
      else if (bp.upd_valid && (up_bidx == BHT_LOG'(g)))      cnt[g] <= cnt_nxt;
    end
  end

  for (genvar g = 0; g < BTB_N; g++) begin : g_btb
    logic wr;
    assign wr = bp.upd_valid && bp.upd_taken && (up_tidx == BTB_LOG'(g));

    always_ff @(posedge clk) begin
      if (rst)     btb_vld[g] <= 1'b0;
      else if (wr) btb_vld[g] <= 1'b1;
    end

    // Tag/target need no reset: a cleared valid bit masks them.
    always_ff @(posedge clk) begin
      if (wr) begin
        btb_tag[g] <= up_tag;
        btb_tgt[g] <= bp.upd_target;
      end
    end
  end

  logic            pred_valid_q, pred_taken_q;
  logic [WORD-1:0] pred_pc_q, pred_target_q, mispred_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_pc_q     <= '0;
      pred_target_q <= '0;
      mispred_q     <= '0;
    end else begin
      // Flush overrides stall; pc/target are don't-care under flush so they just load.
      if (!bp.stall || bp.flush) begin
        pred_valid_q  <= bp.lk_en && !bp.flush;
        pred_taken_q  <= bp.lk_en && !bp.flush && cnt[lk_bidx][1] && lk_hit;
        pred_pc_q     <= bp.lk_pc;
        pred_target_q <= lk_hit ? btb_tgt[lk_tidx] : bp.lk_pc + WORD'(4);
      end
      if (bp.upd_mispredict && !(&mispred_q)) mispred_q <= mispred_q + WORD'(1);
    end
  end

  assign bp.pred_valid  = pred_valid_q;
  assign bp.pred_taken  = pred_taken_q;
  assign bp.pred_pc     = pred_pc_q;
  assign bp.pred_target = pred_target_q;
  assign bp.mispred_cnt = mispred_q;
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboarded bench for branch_predictor_bht: reference model queues expected lookups,
// negedge checker pops them; directed checks cover training, aliasing, stall/flush and counters.
module tb_branch_predictor_bht;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_bht_if #(.WORD(32)) bif ();
  branch_predictor_bht_if #(.WORD(4))  bif4 ();

  branch_predictor_bht dut (.clk(clk), .rst(rst), .bp(bif.slave));
  branch_predictor_bht #(.WORD(4), .BHT_LOG(1), .BTB_LOG(1), .TAG_W(1)) dut4 (
    .clk(clk), .rst(rst), .bp(bif4.slave));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference model: 64 counters, 16-entry BTB with 8-bit tags.
  typedef struct { logic [31:0] pc; logic [31:0] tgt; } exp_t;
  exp_t        q[$];
  logic [1:0]  m_cnt [64];
  logic        m_bv  [16];
  logic [7:0]  m_tag [16];
  logic [31:0] m_tgt [16];
  logic        m_valid, m_taken;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) m_cnt[i] = 2'b01;
      for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
      m_valid = 0; m_taken = 0;
      q.delete();
    end else begin
      logic [5:0] bi; logic [3:0] ti; logic hit; exp_t e;
      bi  = bif.lk_pc[7:2];
      ti  = bif.lk_pc[5:2];
      hit = m_bv[ti] && (m_tag[ti] == bif.lk_pc[13:6]);
      if (bif.flush) begin
        m_valid = 0; m_taken = 0;
      end else if (!bif.stall) begin
        m_valid = bif.lk_en;
        m_taken = bif.lk_en && (m_cnt[bi] >= 2'b10) && hit;
        if (bif.lk_en) begin
          e.pc  = bif.lk_pc;
          e.tgt = hit ? m_tgt[ti] : bif.lk_pc + 32'd4;
          q.push_back(e);
        end
      end
      if (bif.upd_valid) begin
        bi = bif.upd_pc[7:2];
        ti = bif.upd_pc[5:2];
        if (bif.upd_taken) begin
          if (m_cnt[bi] != 2'b11) m_cnt[bi] = m_cnt[bi] + 2'd1;
          m_bv[ti]  = 1'b1;
          m_tag[ti] = bif.upd_pc[13:6];
          m_tgt[ti] = bif.upd_target;
        end else if (m_cnt[bi] != 2'b00) begin
          m_cnt[bi] = m_cnt[bi] - 2'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("sb_valid", {31'b0, bif.pred_valid}, {31'b0, m_valid});
      chk("sb_taken", {31'b0, bif.pred_taken}, {31'b0, m_taken});
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sb_pc", bif.pred_pc, e.pc);
        chk("sb_target", bif.pred_target, e.tgt);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    bif.lk_en = 1; bif.lk_pc = pc; cyc(); bif.lk_en = 0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    bif.upd_valid = 1; bif.upd_pc = pc; bif.upd_taken = tk; bif.upd_target = tgt;
    cyc(); bif.upd_valid = 0;
  endtask

  task automatic expect_pred(input string tag, input logic tk, input logic [31:0] tgt);
    chk({tag, "_taken"}, {31'b0, bif.pred_taken}, {31'b0, tk});
    chk({tag, "_target"}, bif.pred_target, tgt);
  endtask

  localparam logic [31:0] PA = 32'h1C00_0010;
  localparam logic [31:0] PB = 32'h1C00_0110;  // same BHT and BTB index as PA, other tag

  initial begin
    bif.lk_en = 0; bif.lk_pc = '0; bif.stall = 0; bif.flush = 0;
    bif.upd_valid = 0; bif.upd_pc = '0; bif.upd_taken = 0; bif.upd_target = '0;
    bif.upd_mispredict = 0;
    bif4.lk_en = 0; bif4.lk_pc = '0; bif4.stall = 0; bif4.flush = 0;
    bif4.upd_valid = 0; bif4.upd_pc = '0; bif4.upd_taken = 0; bif4.upd_target = '0;
    bif4.upd_mispredict = 0;
    rst = 1; cyc(); cyc(); rst = 0; chk_en = 1;

    chk("rst_valid", {31'b0, bif.pred_valid}, 32'd0);
    chk("rst_target", bif.pred_target, 32'd0);
    chk("rst_mispred", bif.mispred_cnt, 32'd0);
    lookup(32'h1C00_0000);
    chk("first_valid", {31'b0, bif.pred_valid}, 32'd1);
    expect_pred("first", 1'b0, 32'h1C00_0004);

    // 01 -> 10, then saturate at 11, then walk down to 00.
    upd(PA, 1, 32'h1C00_0100);
    lookup(PA);        expect_pred("train1", 1'b1, 32'h1C00_0100);
    upd(PA, 1, 32'h1C00_0100);
    upd(PA, 1, 32'h1C00_0100);
    upd(PA, 0, 32'hDEAD_BEEF); lookup(PA); expect_pred("nt1", 1'b1, 32'h1C00_0100);
    upd(PA, 0, 32'hDEAD_BEEF); lookup(PA); expect_pred("nt2", 1'b0, 32'h1C00_0100);
    upd(PA, 0, 32'hDEAD_BEEF); lookup(PA); expect_pred("nt3", 1'b0, 32'h1C00_0100);
    upd(PA, 0, 32'hDEAD_BEEF); lookup(PA); expect_pred("nt4", 1'b0, 32'h1C00_0100);
    upd(PA, 1, 32'h1C00_0100); lookup(PA); expect_pred("floor", 1'b0, 32'h1C00_0100);

    // Same-cycle lookup and update: read-old, visible next lookup.
    bif.lk_en = 1; bif.lk_pc = PA;
    bif.upd_valid = 1; bif.upd_pc = PA; bif.upd_taken = 1; bif.upd_target = 32'h1C00_0100;
    cyc(); bif.upd_valid = 0;
    expect_pred("rw_old", 1'b0, 32'h1C00_0100);
    cyc(); bif.lk_en = 0;
    expect_pred("rw_new", 1'b1, 32'h1C00_0100);

    // Aliasing: BTB-index alias and full-index alias both miss the BTB.
    lookup(PA + 32'h40); expect_pred("alias_btb", 1'b0, 32'h1C00_0054);
    lookup(PB);          expect_pred("alias_bht", 1'b0, 32'h1C00_0114);
    upd(PB, 1, 32'h1C00_0200);
    lookup(PB);          expect_pred("ovr_new", 1'b1, 32'h1C00_0200);
    lookup(PA);          expect_pred("ovr_old", 1'b0, 32'h1C00_0014);

    // Stall holds outputs while an update and a mispredict still land.
    bif.lk_en = 1; bif.lk_pc = PB; cyc();
    bif.stall = 1;
    for (int i = 0; i < 3; i++) begin
      bif.lk_pc = 32'h1C00_0000 + 32'(i * 4);
      bif.upd_mispredict = (i == 1);
      bif.upd_valid = (i == 0); bif.upd_pc = 32'h1C00_0020;
      bif.upd_taken = 1; bif.upd_target = 32'h1C00_0300;
      cyc();
      chk("stall_pc", bif.pred_pc, PB);
      chk("stall_valid", {31'b0, bif.pred_valid}, 32'd1);
      expect_pred("stall", 1'b1, 32'h1C00_0200);
    end
    bif.upd_valid = 0; bif.upd_mispredict = 0;
    bif.flush = 1; cyc(); bif.flush = 0; bif.stall = 0; bif.lk_en = 0;
    chk("flush_valid", {31'b0, bif.pred_valid}, 32'd0);
    chk("flush_taken", {31'b0, bif.pred_taken}, 32'd0);
    lookup(32'h1C00_0020); expect_pred("stall_upd", 1'b1, 32'h1C00_0300);
    chk("mispred_stall", bif.mispred_cnt, 32'd1);
    bif.upd_mispredict = 1; cyc(); bif.upd_mispredict = 0;
    chk("mispred_novalid", bif.mispred_cnt, 32'd2);

    // Narrow build: saturation of the misprediction counter.
    bif4.upd_mispredict = 1;
    for (int i = 0; i < 13; i++) cyc();
    bif4.upd_mispredict = 0;
    chk("m4_pre", {28'b0, bif4.mispred_cnt}, 32'hD);
    bif4.upd_mispredict = 1; cyc(); cyc(); bif4.upd_mispredict = 0;
    chk("m4_top", {28'b0, bif4.mispred_cnt}, 32'hF);
    bif4.upd_mispredict = 1; cyc(); cyc(); bif4.upd_mispredict = 0;
    chk("m4_sat", {28'b0, bif4.mispred_cnt}, 32'hF);

    // Reset beats a pending update and mispredict.
    rst = 1;
    bif.upd_valid = 1; bif.upd_pc = 32'h1C00_0024; bif.upd_taken = 1;
    bif.upd_target = 32'h1C00_0400; bif.upd_mispredict = 1; bif4.upd_mispredict = 1;
    cyc();
    rst = 0; bif.upd_valid = 0; bif.upd_mispredict = 0; bif4.upd_mispredict = 0;
    chk("rst2_mispred", bif.mispred_cnt, 32'd0);
    chk("rst2_m4", {28'b0, bif4.mispred_cnt}, 32'd0);
    lookup(32'h1C00_0024); expect_pred("rst2_pend", 1'b0, 32'h1C00_0028);
    lookup(32'h1C00_0020); expect_pred("rst2_btb", 1'b0, 32'h1C00_0024);
    lookup(PB);            expect_pred("rst2_pb", 1'b0, 32'h1C00_0114);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
